// File: rtl/gfx_cmd_queue_if.sv
// rtl/gfx_cmd_queue_if.sv - command-in / primitive-out bundle for gfx_cmd_queue
interface gfx_cmd_queue_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [51:0]   cmd_in;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          prim_valid;
    logic          prim_ready;
    logic [2:0]    prim_op;
    logic [9:0]    prim_x0;
    logic [8:0]    prim_y0;
    logic [9:0]    prim_x1;
    logic [8:0]    prim_y1;
    logic [7:0]    prim_color;
    logic [LW-1:0] fifo_level;
    logic [15:0]   drop_cnt;

    modport master (
        output cmd_in, cmd_valid, prim_ready,
        input  cmd_ready, prim_valid, prim_op, prim_x0, prim_y0, prim_x1, prim_y1,
               prim_color, fifo_level, drop_cnt
    );

    modport slave (
        input  cmd_in, cmd_valid, prim_ready,
        output cmd_ready, prim_valid, prim_op, prim_x0, prim_y0, prim_x1, prim_y1,
               prim_color, fifo_level, drop_cnt
    );
endinterface

// File: rtl/gfx_cmd_queue.sv
// rtl/gfx_cmd_queue.sv - decodes/validates 52-bit draw commands and queues primitives
module gfx_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic           clk,
    input  logic           rst_,
    gfx_cmd_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [10:0] XLIM = 11'(H_RES);
    localparam logic [9:0]  YLIM = 10'(V_RES);
    localparam logic [9:0]  XMAX = 10'(H_RES - 1);
    localparam logic [8:0]  YMAX = 9'(V_RES - 1);

    typedef struct packed {
        logic [2:0] op;
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] x1;
        logic [8:0] y1;
        logic [7:0] color;
    } prim_t;

    logic [3:0] c_op;
    logic [9:0] c_x0, c_x1;
    logic [8:0] c_y0, c_y1;
    logic [7:0] c_color;
    logic       unused_rsvd;

    assign c_op        = bus.cmd_in[51:48];
    assign c_x0        = bus.cmd_in[47:38];
    assign c_y0        = bus.cmd_in[37:29];
    assign c_x1        = bus.cmd_in[28:19];
    assign c_y1        = bus.cmd_in[18:10];
    assign c_color     = bus.cmd_in[9:2];
    assign unused_rsvd = ^bus.cmd_in[1:0];

    logic x0_ok, y0_ok, x1_ok, y1_ok;
    assign x0_ok = {1'b0, c_x0} < XLIM;
    assign x1_ok = {1'b0, c_x1} < XLIM;
    assign y0_ok = {1'b0, c_y0} < YLIM;
    assign y1_ok = {1'b0, c_y1} < YLIM;

    prim_t dec;
    logic  dec_ok;
    logic  dec_drop;

    always_comb begin
        dec       = '0;
        dec.op    = c_op[2:0];
        dec.color = c_color;
        dec_ok    = 1'b0;
        case (c_op)
            4'd1: begin
                dec.x0 = c_x0;
                dec.y0 = c_y0;
                dec.x1 = c_x0;
                dec.y1 = c_y0;
                dec_ok = x0_ok && y0_ok;
            end
            4'd2: begin
                dec.x0 = c_x0;
                dec.y0 = c_y0;
                dec.x1 = c_x1;
                dec.y1 = c_y1;
                dec_ok = x0_ok && y0_ok && x1_ok && y1_ok;
            end
            4'd3, 4'd4: begin
                // x and y are swapped independently so the output is always top-left / bottom-right
                dec.x0 = (c_x0 <= c_x1) ? c_x0 : c_x1;
                dec.x1 = (c_x0 <= c_x1) ? c_x1 : c_x0;
                dec.y0 = (c_y0 <= c_y1) ? c_y0 : c_y1;
                dec.y1 = (c_y0 <= c_y1) ? c_y1 : c_y0;
                dec_ok = x0_ok && y0_ok && x1_ok && y1_ok;
            end
            4'd5: begin
                dec.x1 = XMAX;
                dec.y1 = YMAX;
                dec_ok = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
        dec_drop = (c_op != 4'd0) && !dec_ok;
    end

    prim_t          mem [DEPTH];
    prim_t          s1_prim;
    logic           s1_busy;
    logic           s1_push;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic [15:0]    drops;
    logic           accept;
    logic           pop;

    // Counting the stage slot (even for NOP/dropped words) guarantees stage 1 can always drain
    assign bus.cmd_ready = ({1'b0, level} + {{LW{1'b0}}, s1_busy}) < (LW + 1)'(DEPTH);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.prim_valid = (level != '0);
    assign pop           = bus.prim_valid && bus.prim_ready;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            s1_busy <= 1'b0;
            s1_push <= 1'b0;
            s1_prim <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            drops   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            s1_busy <= accept;
            s1_push <= accept && dec_ok;
            if (accept) s1_prim <= dec;
            if (accept && dec_drop && drops != 16'hFFFF) drops <= drops + 16'd1;

            if (s1_push) begin
                mem[wr_ptr] <= s1_prim;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({s1_push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    prim_t head;
    assign head           = mem[rd_ptr];
    assign bus.prim_op    = head.op;
    assign bus.prim_x0    = head.x0;
    assign bus.prim_y0    = head.y0;
    assign bus.prim_x1    = head.x1;
    assign bus.prim_y1    = head.y1;
    assign bus.prim_color = head.color;
    assign bus.fifo_level = level;
    assign bus.drop_cnt   = drops;
endmodule

// File: tb/tb_gfx_cmd_queue.sv
// tb/tb_gfx_cmd_queue.sv - table, corner-case and random checks of gfx_cmd_queue
module tb_gfx_cmd_queue;
    localparam int DEPTH = 8;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0] op;
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] x1;
        logic [8:0] y1;
        logic [7:0] color;
    } prim_t;

    typedef struct {
        logic [51:0] cmd;
        bit          ok;
        bit          drop;
        prim_t       p;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ = 1'b0;

    gfx_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

    gfx_cmd_queue #(.DEPTH(DEPTH), .H_RES(H_RES), .V_RES(V_RES)) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_bad = 0;
    prim_t q[$];
    prim_t popped[$];
    bit    st_busy;
    bit    st_has;
    prim_t st_p;
    int    m_drops;

    function automatic logic [51:0] mk(input int op, input int x0, input int y0,
                                       input int x1, input int y1, input int col);
        return {4'(op), 10'(x0), 9'(y0), 10'(x1), 9'(y1), 8'(col), 2'b00};
    endfunction

    function automatic prim_t pr(input int op, input int x0, input int y0,
                                 input int x1, input int y1, input int col);
        return {3'(op), 10'(x0), 9'(y0), 10'(x1), 9'(y1), 8'(col)};
    endfunction

    // Reference decode written straight from the command rules
    function automatic void decode(input logic [51:0] c, output bit ok, output bit drop,
                                   output prim_t p);
        int op, x0, y0, x1, y1, col;
        op  = int'(c[51:48]);
        x0  = int'(c[47:38]);
        y0  = int'(c[37:29]);
        x1  = int'(c[28:19]);
        y1  = int'(c[18:10]);
        col = int'(c[9:2]);
        ok  = 1'b0;
        p   = pr(op, 0, 0, 0, 0, col);
        case (op)
            1: begin
                ok = (x0 < H_RES) && (y0 < V_RES);
                p  = pr(op, x0, y0, x0, y0, col);
            end
            2: begin
                ok = (x0 < H_RES) && (y0 < V_RES) && (x1 < H_RES) && (y1 < V_RES);
                p  = pr(op, x0, y0, x1, y1, col);
            end
            3, 4: begin
                ok = (x0 < H_RES) && (y0 < V_RES) && (x1 < H_RES) && (y1 < V_RES);
                p  = pr(op, (x0 < x1) ? x0 : x1, (y0 < y1) ? y0 : y1,
                        (x0 < x1) ? x1 : x0, (y0 < y1) ? y1 : y0, col);
            end
            5: begin
                ok = 1'b1;
                p  = pr(op, 0, 0, H_RES - 1, V_RES - 1, col);
            end
            default: ok = 1'b0;
        endcase
        drop = (op != 0) && !ok;
    endfunction

    function automatic prim_t dut_head();
        return {bus.prim_op, bus.prim_x0, bus.prim_y0, bus.prim_x1, bus.prim_y1, bus.prim_color};
    endfunction

    function automatic bit model_ready();
        return (q.size() + int'(st_busy)) < DEPTH;
    endfunction

    task automatic model_reset();
        q.delete();
        popped.delete();
        st_busy = 1'b0;
        st_has  = 1'b0;
        st_p    = '0;
        m_drops = 0;
    endtask

    task automatic check(input string name);
        bit    bad;
        prim_t act;
        prim_t exp;
        bad = 1'b0;
        act = dut_head();
        exp = (q.size() != 0) ? q[0] : act;
        n_vec++;
        if (bus.prim_valid !== (q.size() != 0)) bad = 1'b1;
        if (bus.fifo_level !== LW'(q.size())) bad = 1'b1;
        if (bus.drop_cnt !== 16'(m_drops)) bad = 1'b1;
        if (bus.cmd_ready !== model_ready()) bad = 1'b1;
        if (q.size() != 0 && act !== exp) bad = 1'b1;
        if (bad) begin
            n_bad++;
            $display("FAIL %s t=%0t: got valid=%0b level=%0d drop=%0d ready=%0b head=%h; want valid=%0b level=%0d drop=%0d ready=%0b head=%h",
                     name, $time, bus.prim_valid, bus.fifo_level, bus.drop_cnt, bus.cmd_ready, act,
                     (q.size() != 0), q.size(), m_drops, model_ready(), exp);
        end
    endtask

    task automatic expect_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic expect_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic expect_prim(input string name, input prim_t act, input prim_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock: predict accept/pop from the model, advance the model, then compare
    task automatic cyc(input string name);
        bit    acc, pp, ok, drop;
        prim_t p;
        acc = bus.cmd_valid && model_ready();
        pp  = (q.size() != 0) && bus.prim_ready;
        if (pp) popped.push_back(dut_head());
        @(posedge clk);
        #1;
        if (pp) void'(q.pop_front());
        if (st_has) q.push_back(st_p);
        st_busy = acc;
        st_has  = 1'b0;
        if (acc) begin
            decode(bus.cmd_in, ok, drop, p);
            st_has = ok;
            st_p   = p;
            if (drop && m_drops < 65535) m_drops++;
        end
        check(name);
    endtask

    vec_t  tv[13];
    prim_t lines[12];
    int    k;
    int    d0;
    bit    acc_pred;

    initial begin
        bus.cmd_in     = '0;
        bus.cmd_valid  = 1'b0;
        bus.prim_ready = 1'b0;
        model_reset();

        tv[0]  = '{mk(3, 100, 50, 20, 10, 'hA5),    1, 0, pr(3, 20, 10, 100, 50, 'hA5)};
        tv[1]  = '{mk(0, 1, 2, 3, 4, 5),            0, 0, '0};
        tv[2]  = '{mk(9, 1, 2, 3, 4, 5),            0, 1, '0};
        tv[3]  = '{mk(1, 640, 5, 0, 0, 1),          0, 1, '0};
        tv[4]  = '{mk(1, 639, 479, 3, 4, 7),        1, 0, pr(1, 639, 479, 639, 479, 7)};
        tv[5]  = '{mk(1, 5, 6, 700, 500, 1),        1, 0, pr(1, 5, 6, 5, 6, 1)};
        tv[6]  = '{mk(2, 10, 20, 5, 470, 3),        1, 0, pr(2, 10, 20, 5, 470, 3)};
        tv[7]  = '{mk(2, 10, 20, 640, 0, 3),        0, 1, '0};
        tv[8]  = '{mk(5, 1000, 511, 1023, 511, 'hFF), 1, 0, pr(5, 0, 0, 639, 479, 'hFF)};
        tv[9]  = '{mk(4, 5, 400, 600, 100, 'h12),   1, 0, pr(4, 5, 100, 600, 400, 'h12)};
        tv[10] = '{mk(3, 0, 479, 639, 480, 1),      0, 1, '0};
        tv[11] = '{mk(15, 0, 0, 0, 0, 0),           0, 1, '0};
        tv[12] = '{mk(4, 639, 0, 639, 0, 9),        1, 0, pr(4, 639, 0, 639, 0, 9)};

        #12;
        expect_bit("reset_prim_valid", bus.prim_valid, 1'b0);
        expect_bit("reset_cmd_ready", bus.cmd_ready, 1'b1);
        expect_int("reset_level", int'(bus.fifo_level), 0);
        expect_int("reset_drop", int'(bus.drop_cnt), 0);
        expect_prim("reset_head", dut_head(), '0);
        @(negedge clk);
        rst_ = 1'b1;

        for (int i = 0; i < 13; i++) begin
            d0 = m_drops;
            bus.prim_ready = 1'b0;
            bus.cmd_in     = tv[i].cmd;
            bus.cmd_valid  = 1'b1;
            cyc("tbl_accept");
            bus.cmd_valid  = 1'b0;
            cyc("tbl_stage");
            expect_bit($sformatf("tbl%0d_valid", i), bus.prim_valid, tv[i].ok);
            expect_int($sformatf("tbl%0d_drop", i), int'(bus.drop_cnt), d0 + int'(tv[i].drop));
            if (tv[i].ok) begin
                expect_prim($sformatf("tbl%0d_prim", i), dut_head(), tv[i].p);
                bus.prim_ready = 1'b1;
                cyc("tbl_pop");
            end
        end

        // Back-pressure: 12 LINEs against a stalled rasteriser
        popped.delete();
        bus.prim_ready = 1'b0;
        for (int i = 0; i < 12; i++) lines[i] = pr(2, i * 10, i, 600 - i, 400 + i, i + 1);
        k = 0;
        for (int c = 0; c < 15; c++) begin
            bus.cmd_valid = (k < 12);
            bus.cmd_in    = mk(2, k * 10, k, 600 - k, 400 + k, k + 1);
            acc_pred      = bus.cmd_valid && model_ready();
            cyc("bp_fill");
            if (acc_pred) k++;
        end
        expect_int("bp_accepted", k, 8);
        expect_int("bp_level_full", int'(bus.fifo_level), 8);
        expect_bit("bp_ready_low", bus.cmd_ready, 1'b0);
        expect_prim("bp_head_stable", dut_head(), lines[0]);
        bus.prim_ready = 1'b1;
        for (int c = 0; c < 100 && (k < 12 || q.size() != 0 || st_busy); c++) begin
            bus.cmd_valid = (k < 12);
            bus.cmd_in    = mk(2, k * 10, k, 600 - k, 400 + k, k + 1);
            acc_pred      = bus.cmd_valid && model_ready();
            cyc("bp_drain");
            if (acc_pred) k++;
        end
        bus.cmd_valid = 1'b0;
        expect_int("bp_popped_count", popped.size(), 12);
        for (int i = 0; i < 12 && i < popped.size(); i++)
            expect_prim($sformatf("bp_order%0d", i), popped[i], lines[i]);

        // Fill, then push and pop together at full
        bus.prim_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_in    = mk(1, c, c, 0, 0, c);
            cyc("full_fill");
        end
        expect_int("full_level", int'(bus.fifo_level), 8);
        bus.prim_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.cmd_in = mk(2, c, c + 1, c + 2, c + 3, 'h40 + c);
            cyc("full_pushpop");
        end
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 12; c++) cyc("full_drain");

        // Asynchronous reset with entries buffered
        bus.prim_ready = 1'b0;
        bus.cmd_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.cmd_in = mk(5, 0, 0, 0, 0, c);
            cyc("rst_load");
        end
        bus.cmd_in = mk(7, 0, 0, 0, 0, 0);
        cyc("rst_load_drop");
        bus.cmd_valid = 1'b0;
        cyc("rst_load_settle");
        expect_int("rst_pre_level", int'(bus.fifo_level), 4);
        #2;
        rst_ = 1'b0;
        #1;
        expect_bit("rst_async_valid", bus.prim_valid, 1'b0);
        expect_int("rst_async_level", int'(bus.fifo_level), 0);
        expect_int("rst_async_drop", int'(bus.drop_cnt), 0);
        expect_bit("rst_async_ready", bus.cmd_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_ = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_in    = tv[9].cmd;
        cyc("rst_after_accept");
        bus.cmd_valid = 1'b0;
        cyc("rst_after_stage");
        expect_bit("rst_after_valid", bus.prim_valid, 1'b1);
        expect_prim("rst_after_prim", dut_head(), tv[9].p);

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            int op, x0, y0, x1, y1;
            op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 15));
            x0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 639));
            x1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 639));
            y0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 479));
            y1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 479));
            bus.cmd_in     = mk(op, x0, y0, x1, y1, int'($urandom_range(0, 255))) | 52'($urandom_range(0, 3));
            bus.cmd_valid  = ($urandom_range(0, 3) != 0);
            bus.prim_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
